// File: rtl/eq_pkg.sv
// Shared types and constants for the slide-pot sequencer: FSM states,
// pot indices in sweep order, and the index -> ADC128S channel mapping.
package eq_pkg;

    localparam int unsigned POT_W    = 12;
    localparam int unsigned NUM_POTS = 6;

    typedef enum logic [1:0] {
        ST_GAP,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_e;

    typedef enum logic [2:0] {
        IDX_LP,
        IDX_B1,
        IDX_B2,
        IDX_B3,
        IDX_HP,
        IDX_VOL
    } pot_idx_e;

    localparam logic [2:0] CHNNL_CODE [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

    function automatic pot_idx_e next_idx(input pot_idx_e idx);
        return (idx == IDX_VOL) ? IDX_LP : pot_idx_e'(idx + 3'd1);
    endfunction

endpackage

// File: rtl/pot_reg_bank.sv
// Six held 12-bit pot registers with a single indexed write port.
module pot_reg_bank
    import eq_pkg::*;
#(
    parameter logic [POT_W-1:0] RESET_GAIN = 12'h800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  pot_idx_e         i_idx,
    input  logic [POT_W-1:0] i_wdata,
    output logic [POT_W-1:0] o_pot [NUM_POTS]
);

    logic [POT_W-1:0] r_pot [NUM_POTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_POTS; i++) begin
                r_pot[i] <= RESET_GAIN;
            end
        end else if (i_we) begin
            r_pot[i_idx] <= i_wdata;
        end
    end

    assign o_pot = r_pot;

endmodule

// File: rtl/slide_pot_sequencer.sv
// Round-robin conversion scheduler for the six slide pots on the shared
// ADC128S SPI interface; sole driver of strt_cnv.
module slide_pot_sequencer
    import eq_pkg::*;
#(
    parameter int unsigned      GAP_CYCLES     = 1024,
    parameter int unsigned      TIMEOUT_CYCLES = 4096,
    parameter logic [POT_W-1:0] RESET_GAIN     = 12'h800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    input  logic             cnv_cmplt,
    input  logic [POT_W-1:0] res,
    output logic [POT_W-1:0] pot_lp,
    output logic [POT_W-1:0] pot_b1,
    output logic [POT_W-1:0] pot_b2,
    output logic [POT_W-1:0] pot_b3,
    output logic [POT_W-1:0] pot_hp,
    output logic [POT_W-1:0] volume,
    output logic             sweep_done,
    output logic             all_valid,
    output logic             timeout_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    pot_idx_e         r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_bad;
    logic             r_strt_cnv;
    logic [2:0]       r_chnnl;
    logic             r_sweep_done;
    logic             r_all_valid;
    logic             r_timeout_err;

    logic             w_we;
    logic [POT_W-1:0] w_pot [NUM_POTS];

    assign w_we = (r_state == ST_WAIT) && cnv_cmplt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_GAP;
            r_idx         <= IDX_LP;
            r_gap_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_bad         <= 1'b0;
            r_strt_cnv    <= 1'b0;
            r_chnnl       <= CHNNL_CODE[IDX_LP];
            r_sweep_done  <= 1'b0;
            r_all_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_strt_cnv    <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_GAP: begin
                    if (en) begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_gap_cnt  <= '0;
                            r_tmo_cnt  <= '0;
                            r_strt_cnv <= 1'b1;
                            r_chnnl    <= CHNNL_CODE[r_idx];
                            r_state    <= ST_START;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                // The timeout window counts from the strt_cnv cycle itself.
                ST_START: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnv_cmplt) begin
                        r_state <= ST_STORE;
                    end else if (r_tmo_cnt >= TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_bad         <= 1'b1;
                        r_state       <= ST_STORE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_STORE: begin
                    // Bad flag spans the whole sweep so any timeout blocks all_valid.
                    if (r_idx == IDX_VOL) begin
                        r_sweep_done <= 1'b1;
                        if (!r_bad) begin
                            r_all_valid <= 1'b1;
                        end
                        r_bad <= 1'b0;
                    end
                    r_idx   <= next_idx(r_idx);
                    r_state <= ST_GAP;
                end
                default: r_state <= ST_GAP;
            endcase
        end
    end

    pot_reg_bank #(
        .RESET_GAIN(RESET_GAIN)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_we),
        .i_idx  (r_idx),
        .i_wdata(res),
        .o_pot  (w_pot)
    );

    assign strt_cnv    = r_strt_cnv;
    assign chnnl       = r_chnnl;
    assign sweep_done  = r_sweep_done;
    assign all_valid   = r_all_valid;
    assign timeout_err = r_timeout_err;
    assign pot_lp      = w_pot[IDX_LP];
    assign pot_b1      = w_pot[IDX_B1];
    assign pot_b2      = w_pot[IDX_B2];
    assign pot_b3      = w_pot[IDX_B3];
    assign pot_hp      = w_pot[IDX_HP];
    assign volume      = w_pot[IDX_VOL];

endmodule

// File: tb/tb_slide_pot_sequencer.sv
// Directed + randomized bench: an A2D responder drives the DUT and a
// sweep-level model tracks the expected pot values and status flags.
module tb_slide_pot_sequencer;

    localparam int unsigned GAP  = 4;
    localparam int unsigned TMO  = 16;
    localparam int          LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst, en, cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv, sweep_done, all_valid, timeout_err;
    logic [2:0]  chnnl;
    logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume;

    int checks   = 0;
    int failures = 0;

    // Model state: expected pot contents, sweep position and flags.
    logic [11:0] m_pot [6];
    int          m_idx;
    bit          m_valid, m_bad;
    int          m_code [6] = '{1, 0, 4, 2, 3, 7};

    always #5 clk = ~clk;

    slide_pot_sequencer #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .RESET_GAIN    (12'h800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .pot_lp     (pot_lp),
        .pot_b1     (pot_b1),
        .pot_b2     (pot_b2),
        .pot_b3     (pot_b3),
        .pot_hp     (pot_hp),
        .volume     (volume),
        .sweep_done (sweep_done),
        .all_valid  (all_valid),
        .timeout_err(timeout_err)
    );

    function automatic logic [11:0] dut_pot(input int i);
        case (i)
            0:       return pot_lp;
            1:       return pot_b1;
            2:       return pot_b2;
            3:       return pot_b3;
            4:       return pot_hp;
            default: return volume;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_pot[i] = 12'h800;
        m_idx   = 0;
        m_valid = 0;
        m_bad   = 0;
    endtask

    task automatic chk_all_pots(input string tag);
        for (int i = 0; i < 6; i++) chk($sformatf("%s_pot%0d", tag, i), dut_pot(i), m_pot[i]);
    endtask

    // Wait for strt_cnv; exp_cnt < 0 skips the latency check.
    task automatic wait_strt(input int exp_cnt, input string tag);
        int n = 0;
        while (!strt_cnv && n < LIMIT) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, strt_cnv, 1'b1);
        if (exp_cnt >= 0) chk({tag, "_lat"}, n, exp_cnt);
    endtask

    // Called at the STORE cycle; advances into GAP and checks sweep flags.
    task automatic finish_store();
        tick();
        chk("sweep_done", sweep_done, (m_idx == 5));
        chk("no_stray_tmo", timeout_err, 1'b0);
        if (m_idx == 5) begin
            if (!m_bad) m_valid = 1;
            m_bad = 0;
        end
        chk("all_valid", all_valid, m_valid);
        m_idx = (m_idx + 1) % 6;
    endtask

    // Called in the strt_cnv cycle; answers in the d-th cycle after it.
    task automatic serve(input int d, input logic [11:0] r);
        chk("chnnl_start", chnnl, m_code[m_idx]);
        for (int k = 0; k < d; k++) begin
            tick();
            if (k == 0) chk("strt_one_cycle", strt_cnv, 1'b0);
        end
        chk("chnnl_hold", chnnl, m_code[m_idx]);
        cnv_cmplt = 1'b1;
        res       = r;
        tick();
        cnv_cmplt = 1'b0;
        res       = 12'($urandom);
        m_pot[m_idx] = r;
        chk("pot_write", dut_pot(m_idx), m_pot[m_idx]);
        chk("no_tmo_on_cmplt", timeout_err, 1'b0);
        finish_store();
    endtask

    task automatic no_answer();
        chk("chnnl_start_tmo", chnnl, m_code[m_idx]);
        repeat (TMO - 1) tick();
        chk("tmo_early", timeout_err, 1'b0);
        tick();
        chk("tmo_pulse", timeout_err, 1'b1);
        chk("tmo_pot_kept", dut_pot(m_idx), m_pot[m_idx]);
        m_bad = 1;
        finish_store();
    endtask

    task automatic spurious(input logic [11:0] r);
        cnv_cmplt = 1'b1;
        res       = r;
        tick();
        cnv_cmplt = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; en = 1'b1; cnv_cmplt = 1'b0; res = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        chk_all_pots("reset");
        chk("reset_all_valid", all_valid, 1'b0);
        chk("reset_strt", strt_cnv, 1'b0);
        chk("reset_chnnl", chnnl, 3'd1);
        chk("reset_sweep_done", sweep_done, 1'b0);
        wait_strt(GAP, "first");
        chk("first_chnnl", chnnl, 3'd1);

        // Clean directed sweep.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) wait_strt(GAP, "sweep1");
            serve($urandom_range(1, 12), 12'((i + 1) * 12'h100));
        end
        chk_all_pots("sweep1");
        chk("sweep1_valid", all_valid, 1'b1);
        wait_strt(GAP, "wrap");
        chk("wrap_chnnl", chnnl, 3'd1);

        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        chk_all_pots("rst2");

        // Sweep with a B2 timeout and a B3 answer in the timeout cycle.
        wait_strt(GAP, "tsw_lp"); serve($urandom_range(1, 12), 12'($urandom));
        wait_strt(GAP, "tsw_b1"); serve($urandom_range(1, 12), 12'($urandom));
        wait_strt(GAP, "tsw_b2"); no_answer();
        wait_strt(GAP, "tsw_b3"); serve(TMO - 1, 12'hABC);
        chk("race_value", pot_b3, 12'hABC);
        wait_strt(GAP, "tsw_hp"); serve($urandom_range(1, 12), 12'($urandom));
        wait_strt(GAP, "tsw_vol"); serve($urandom_range(1, 12), 12'($urandom));
        chk("tsw_not_valid", all_valid, 1'b0);
        chk_all_pots("tsw");

        // Randomized clean sweeps.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++) begin
                wait_strt(GAP, "rnd");
                serve($urandom_range(1, TMO - 1), 12'($urandom));
            end
        end
        chk_all_pots("rnd");
        chk("rnd_valid", all_valid, 1'b1);

        // cnv_cmplt while in GAP must not write.
        spurious(12'hFFF);
        chk_all_pots("spur");
        wait_strt(GAP - 1, "spur");
        serve($urandom_range(1, 12), 12'($urandom));

        // en low in GAP holds the count.
        tick(); tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        wait_strt(GAP - 2, "gap_hold");

        // en dropped during a conversion: it completes, then sequencing stops.
        en = 1'b0;
        serve($urandom_range(1, 12), 12'($urandom));
        seen = 0;
        repeat (20) begin
            tick();
            if (strt_cnv) seen = 1;
        end
        chk("en_off_no_strt", seen, 1'b0);
        en = 1'b1;
        wait_strt(GAP, "en_on");

        // Reset while waiting for a result, then a late cnv_cmplt.
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        chk_all_pots("rst_wait");
        chk("rst_wait_valid", all_valid, 1'b0);
        chk("rst_wait_chnnl", chnnl, 3'd1);
        spurious(12'h123);
        chk_all_pots("late");
        wait_strt(GAP - 1, "after_rst");
        serve($urandom_range(1, 12), 12'h5A5);
        chk_all_pots("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
